mem_port_arbiter: RTL and testbench

- Shares the single 128-bit external memory port (addr/wdata/we/cs out; rdata/rvalid in) between three requesters: D-cache refill/writeback, I-cache refill and AES MMIO writes.
- Sits between the pipeline's MEM/IF cache controllers and the memory/peripheral interconnect.
- Arbitrates round-robin and holds the grant until the transaction completes.
- A watchdog terminates any transaction the memory never answers, so the cores cannot hang.

---
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 128-bit memory port between D-cache, I-cache and AES MMIO.
// Holds the grant until the memory completes or the watchdog force-terminates the transaction.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              dc_req_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [DATA_W-1:0] dc_wdata_i,
  input  logic              dc_we_i,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  input  logic              aes_req_i,
  input  logic [ADDR_W-1:0] aes_addr_i,
  input  logic [DATA_W-1:0] aes_wdata_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              we_o,
  output logic              cs_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_rvalid_i,
  output logic              dc_rvalid_o,
  output logic              ic_rvalid_o,
  output logic              aes_rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic [2:0]        grant_o,
  output logic              busy_o
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           r_state;
  logic [1:0]       r_last;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       w_pick;
  logic             w_busy;
  logic             w_timeout;
  logic             w_done;

  // Round-robin pick: search starts one past the last owner.
  always_comb begin
    w_pick = 3'b000;
    case (r_last)
      2'd0: begin
        if (ic_req_i)       w_pick = 3'b010;
        else if (aes_req_i) w_pick = 3'b100;
        else if (dc_req_i)  w_pick = 3'b001;
      end
      2'd1: begin
        if (aes_req_i)      w_pick = 3'b100;
        else if (dc_req_i)  w_pick = 3'b001;
        else if (ic_req_i)  w_pick = 3'b010;
      end
      default: begin
        if (dc_req_i)       w_pick = 3'b001;
        else if (ic_req_i)  w_pick = 3'b010;
        else if (aes_req_i) w_pick = 3'b100;
      end
    endcase
  end

  assign w_busy    = (r_state == BUSY);
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
  assign w_done    = w_busy && (mem_rvalid_i || w_timeout);

  // Completion is reported in the same cycle the memory (or the watchdog) ends the transaction.
  assign dc_rvalid_o  = w_done & grant_o[0];
  assign ic_rvalid_o  = w_done & grant_o[1];
  assign aes_rvalid_o = w_done & grant_o[2];
  assign err_o        = w_busy && !mem_rvalid_i && w_timeout;
  assign rdata_o      = (w_busy && mem_rvalid_i) ? mem_rdata_i : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_last  <= 2'd2;
      r_cnt   <= '0;
      grant_o <= 3'b000;
      cs_o    <= 1'b0;
      we_o    <= 1'b0;
      busy_o  <= 1'b0;
      addr_o  <= '0;
      wdata_o <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick != 3'b000) begin
            r_state <= BUSY;
            r_cnt   <= '0;
            grant_o <= w_pick;
            cs_o    <= 1'b1;
            busy_o  <= 1'b1;
            if (w_pick[0]) begin
              addr_o  <= dc_addr_i;
              wdata_o <= dc_wdata_i;
              we_o    <= dc_we_i;
              r_last  <= 2'd0;
            end else if (w_pick[1]) begin
              addr_o  <= ic_addr_i;
              wdata_o <= '0;
              we_o    <= 1'b0;
              r_last  <= 2'd1;
            end else begin
              addr_o  <= aes_addr_i;
              wdata_o <= aes_wdata_i;
              we_o    <= 1'b1;
              r_last  <= 2'd2;
            end
          end
        end
        BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_done) begin
            r_state <= IDLE;
            grant_o <= 3'b000;
            cs_o    <= 1'b0;
            we_o    <= 1'b0;
            busy_o  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, hand-written corner sequences and a
// randomized run checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 128;
  localparam int          TO = 8;

  localparam logic [AW-1:0] A_DC  = 32'h0000_1000;
  localparam logic [AW-1:0] A_IC  = 32'h0000_2000;
  localparam logic [AW-1:0] A_AES = 32'h0000_0040;
  localparam logic [DW-1:0] W_DC  = 128'hD0D0;
  localparam logic [DW-1:0] W_AES = 128'h1234;

  logic          clk = 1'b0;
  logic          rst;
  logic          dc_req, dc_we, ic_req, aes_req;
  logic [AW-1:0] dc_addr, ic_addr, aes_addr, addr_o;
  logic [DW-1:0] dc_wdata, aes_wdata, wdata_o, mem_rdata, rdata_o;
  logic          we_o, cs_o, mem_rvalid, dc_rv, ic_rv, aes_rv, err_o, busy_o;
  logic [2:0]    grant_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .dc_req_i(dc_req), .dc_addr_i(dc_addr), .dc_wdata_i(dc_wdata), .dc_we_i(dc_we),
    .ic_req_i(ic_req), .ic_addr_i(ic_addr),
    .aes_req_i(aes_req), .aes_addr_i(aes_addr), .aes_wdata_i(aes_wdata),
    .addr_o(addr_o), .wdata_o(wdata_o), .we_o(we_o), .cs_o(cs_o),
    .mem_rdata_i(mem_rdata), .mem_rvalid_i(mem_rvalid),
    .dc_rvalid_o(dc_rv), .ic_rvalid_o(ic_rv), .aes_rvalid_o(aes_rv),
    .rdata_o(rdata_o), .err_o(err_o), .grant_o(grant_o), .busy_o(busy_o)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; dc_req = 1'b0; ic_req = 1'b0; aes_req = 1'b0; mem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]    req;
    logic          dc_we;
    int            lat;      // BUSY cycle (1-based) in which memory answers; 0 = never
    logic [DW-1:0] rdata;
    logic [2:0]    exp_grant;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    logic          exp_we;
    logic          exp_err;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] req, input logic we, input int lat,
                              input logic [DW-1:0] rd, input logic [2:0] eg,
                              input logic [AW-1:0] ea, input logic [DW-1:0] ew,
                              input logic ewe, input logic eerr);
    vec_t v;
    v.req = req; v.dc_we = we; v.lat = lat; v.rdata = rd; v.exp_grant = eg;
    v.exp_addr = ea; v.exp_wdata = ew; v.exp_we = ewe; v.exp_err = eerr;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int n);
    bit done;
    dc_req = v.req[0]; ic_req = v.req[1]; aes_req = v.req[2]; dc_we = v.dc_we;
    dc_addr = A_DC; ic_addr = A_IC; aes_addr = A_AES; dc_wdata = W_DC; aes_wdata = W_AES;
    mem_rvalid = 1'b0; mem_rdata = v.rdata;
    @(negedge clk);
    chk($sformatf("v%0d pre_grant", n), DW'(grant_o), DW'(3'b000));
    chkb($sformatf("v%0d pre_cs", n), cs_o, 1'b0);
    @(posedge clk); #1;
    done = 1'b0;
    for (int c = 1; c <= TO && !done; c++) begin
      mem_rvalid = (c == v.lat);
      if (c == 2) begin
        dc_addr = 32'hDEAD_0000; ic_addr = 32'hBEEF_0000; aes_addr = 32'hCAFE_0000;
        dc_wdata = '1; aes_wdata = '1;
      end
      @(negedge clk);
      chk($sformatf("v%0d c%0d grant", n, c), DW'(grant_o), DW'(v.exp_grant));
      chkb($sformatf("v%0d c%0d cs", n, c), cs_o, 1'b1);
      chkb($sformatf("v%0d c%0d busy", n, c), busy_o, 1'b1);
      chkb($sformatf("v%0d c%0d we", n, c), we_o, v.exp_we);
      chk($sformatf("v%0d c%0d addr", n, c), DW'(addr_o), DW'(v.exp_addr));
      chk($sformatf("v%0d c%0d wdata", n, c), wdata_o, v.exp_wdata);
      if (c == v.lat || c == TO) begin
        done = 1'b1;
        chk($sformatf("v%0d rvalid", n), DW'({aes_rv, ic_rv, dc_rv}), DW'(v.exp_grant));
        chkb($sformatf("v%0d err", n), err_o, v.exp_err);
        chk($sformatf("v%0d rdata", n), rdata_o, v.exp_err ? '0 : v.rdata);
      end else begin
        chk($sformatf("v%0d c%0d rvalid", n, c), DW'({aes_rv, ic_rv, dc_rv}), DW'(3'b000));
      end
      @(posedge clk); #1;
    end
    // Requester drops; a stray completion arrives while IDLE.
    dc_req = 1'b0; ic_req = 1'b0; aes_req = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = '1;
    @(negedge clk);
    chkb($sformatf("v%0d post_cs", n), cs_o, 1'b0);
    chk($sformatf("v%0d post_grant", n), DW'(grant_o), DW'(3'b000));
    chkb($sformatf("v%0d post_busy", n), busy_o, 1'b0);
    chk($sformatf("v%0d stray_rvalid", n), DW'({aes_rv, ic_rv, dc_rv}), DW'(3'b000));
    chk($sformatf("v%0d stray_rdata", n), rdata_o, '0);
    chkb($sformatf("v%0d stray_err", n), err_o, 1'b0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
  endtask

  // ---------------- reference model ----------------
  int            m_owner;   // -1 when no transaction is outstanding
  int            m_last;
  int            m_cnt;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_we;
  logic [2:0]    m_done;

  task automatic model_check(input int cyc);
    logic       busy, fire_to;
    logic [2:0] eg;
    busy    = (m_owner >= 0);
    fire_to = busy && (m_cnt == TO - 1);
    eg      = busy ? 3'(1 << m_owner) : 3'b000;
    m_done  = (busy && (mem_rvalid || fire_to)) ? eg : 3'b000;
    chk($sformatf("r%0d grant", cyc), DW'(grant_o), DW'(eg));
    chkb($sformatf("r%0d cs", cyc), cs_o, busy);
    chkb($sformatf("r%0d busy", cyc), busy_o, busy);
    chk($sformatf("r%0d rvalid", cyc), DW'({aes_rv, ic_rv, dc_rv}), DW'(m_done));
    chkb($sformatf("r%0d err", cyc), err_o, busy && !mem_rvalid && fire_to);
    chk($sformatf("r%0d rdata", cyc), rdata_o, (busy && mem_rvalid) ? mem_rdata : '0);
    if (busy) begin
      chk($sformatf("r%0d addr", cyc), DW'(addr_o), DW'(m_addr));
      chk($sformatf("r%0d wdata", cyc), wdata_o, m_wdata);
      chkb($sformatf("r%0d we", cyc), we_o, m_we);
    end
  endtask

  task automatic model_step();
    logic [2:0] reqs;
    int         idx;
    reqs = {aes_req, ic_req, dc_req};
    if (rst) begin
      m_owner = -1; m_last = 2; m_cnt = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= 3; k++) begin
        idx = (m_last + k) % 3;
        if (m_owner < 0 && reqs[idx]) m_owner = idx;
      end
      if (m_owner >= 0) begin
        m_last = m_owner; m_cnt = 0;
        case (m_owner)
          0:       begin m_addr = dc_addr;  m_wdata = dc_wdata;  m_we = dc_we; end
          1:       begin m_addr = ic_addr;  m_wdata = '0;        m_we = 1'b0;  end
          default: begin m_addr = aes_addr; m_wdata = aes_wdata; m_we = 1'b1;  end
        endcase
      end
    end else if (m_done != 3'b000) begin
      m_owner = -1;
    end else begin
      m_cnt++;
    end
  endtask

  // ---------------- main sequence ----------------
  vec_t       vecs[9];
  logic [2:0] exp_g[8];
  int         p_tab[4];

  initial begin
    int p;
    rst = 1'b1; dc_req = 0; dc_we = 0; ic_req = 0; aes_req = 0; mem_rvalid = 0;
    dc_addr = '0; ic_addr = '0; aes_addr = '0; dc_wdata = '0; aes_wdata = '0; mem_rdata = '0;

    vecs[0] = mk(3'b001, 1'b0, 3, {16{8'hA5}}, 3'b001, A_DC,  W_DC,  1'b0, 1'b0);
    vecs[1] = mk(3'b111, 1'b0, 1, 128'h11,     3'b010, A_IC,  '0,    1'b0, 1'b0);
    vecs[2] = mk(3'b111, 1'b0, 1, 128'h22,     3'b100, A_AES, W_AES, 1'b1, 1'b0);
    vecs[3] = mk(3'b111, 1'b1, 2, 128'h33,     3'b001, A_DC,  W_DC,  1'b1, 1'b0);
    vecs[4] = mk(3'b101, 1'b0, 1, 128'h44,     3'b100, A_AES, W_AES, 1'b1, 1'b0);
    vecs[5] = mk(3'b010, 1'b0, 0, 128'h55,     3'b010, A_IC,  '0,    1'b0, 1'b1);
    vecs[6] = mk(3'b010, 1'b0, 8, 128'h77,     3'b010, A_IC,  '0,    1'b0, 1'b0);
    vecs[7] = mk(3'b011, 1'b0, 2, 128'h88,     3'b001, A_DC,  W_DC,  1'b0, 1'b0);
    vecs[8] = mk(3'b100, 1'b0, 1, 128'h99,     3'b100, A_AES, W_AES, 1'b1, 1'b0);
    exp_g = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    p_tab = '{0, 2, 5, 10};

    // Reset values
    do_reset();
    @(negedge clk);
    chk("rst_grant", DW'(grant_o), DW'(3'b000));
    chkb("rst_cs", cs_o, 1'b0);
    chkb("rst_we", we_o, 1'b0);
    chk("rst_addr", DW'(addr_o), '0);
    chk("rst_wdata", wdata_o, '0);
    chkb("rst_busy", busy_o, 1'b0);
    chkb("rst_err", err_o, 1'b0);
    chk("rst_rvalid", DW'({aes_rv, ic_rv, dc_rv}), DW'(3'b000));
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // All three hold requests, memory answers every cycle: dc, ic, aes, dc with idle gaps.
    do_reset();
    dc_req = 1; ic_req = 1; aes_req = 1; dc_we = 0; mem_rvalid = 1; mem_rdata = 128'h5A;
    dc_addr = A_DC; ic_addr = A_IC; aes_addr = A_AES;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("rr%0d grant", i), DW'(grant_o), DW'(exp_g[i]));
      if (i == 5) chkb("rr aes we", we_o, 1'b1);
      @(posedge clk); #1;
    end

    // Reset in BUSY cycle 2 of a dc write abandons it; dc wins first afterwards.
    do_reset();
    dc_req = 1; ic_req = 0; aes_req = 0; dc_we = 1; mem_rvalid = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chkb("rb cs busy1", cs_o, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chkb("rb no rvalid c2", dc_rv, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; dc_req = 1; ic_req = 1;
    @(negedge clk);
    chkb("rb cs after", cs_o, 1'b0);
    chk("rb grant after", DW'(grant_o), DW'(3'b000));
    chkb("rb rvalid after", dc_rv, 1'b0);
    chkb("rb err after", err_o, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rb first grant", DW'(grant_o), DW'(3'b001));
    @(posedge clk); #1;

    // Randomized run against the reference model.
    do_reset();
    m_owner = -1; m_last = 2; m_cnt = 0; m_done = 3'b000;
    m_addr = '0; m_wdata = '0; m_we = 1'b0;
    p = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 250 == 0) p = p_tab[(cyc / 250) % 4];
      rst = ($urandom_range(0, 199) == 0);
      if (m_done[0]) dc_req = 1'b0;  else if (!dc_req)  dc_req  = ($urandom_range(0, 3) == 0);
      if (m_done[1]) ic_req = 1'b0;  else if (!ic_req)  ic_req  = ($urandom_range(0, 3) == 0);
      if (m_done[2]) aes_req = 1'b0; else if (!aes_req) aes_req = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) begin
        dc_addr = $urandom; dc_we = 1'($urandom_range(0, 1));
        dc_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      if ($urandom_range(0, 3) == 0) ic_addr = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        aes_addr = $urandom; aes_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      mem_rvalid = ($urandom_range(0, 9) < p);
      mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      model_check(cyc);
      @(posedge clk);
      model_step();
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL sim_time_limit: got timeout expected finish");
    $fatal(1);
  end

endmodule
